alu_exec_sequencer: RTL

Multi-cycle controller that sequences the combinational ALU for one instruction at a time. It accepts a 32-bit MIPS instruction and its PC over a valid/ready handshake, then reads the register file, drives the ALU inputs and captures RESULT/SIG_B. It finishes with either a register write-back or a branch resolution (taken flag and target). It sits between fetch and the register file/ALU in the phase-1 datapath.

---
 rtl/alu_exec_sequencer_pkg.sv | 38 +++
 rtl/alu_exec_sequencer_instr_field_decode.sv | 26 ++
 rtl/alu_exec_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and write-back classes
// for the multi-cycle ALU execution sequencer.
package alu_exec_sequencer_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RTYPE_WB = 2'd0,
        ITYPE_WB = 2'd1,
        BRANCH   = 2'd2,
        ILLEGAL  = 2'd3
    } wb_kind_t;

    function automatic wb_kind_t classify_opcode(input logic [5:0] opcode);
        wb_kind_t kind;
        case (opcode)
            OP_RTYPE:                          kind = RTYPE_WB;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: kind = ITYPE_WB;
            OP_BEQ, OP_BNE:                    kind = BRANCH;
            default:                           kind = ILLEGAL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_instr_field_decode.sv
// Combinational split of a latched MIPS instruction word into its fields,
// plus the write-back class that selects what the WB cycle does.
module instr_field_decode
    import alu_exec_sequencer_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_funct,
    output logic [15:0] o_imm,
    output wb_kind_t    o_wb_kind
);

    assign o_opcode  = i_instr[31:26];
    assign o_rs      = i_instr[25:21];
    assign o_rt      = i_instr[20:16];
    assign o_rd      = i_instr[15:11];
    assign o_shamt   = i_instr[10:6];
    assign o_funct   = i_instr[5:0];
    assign o_imm     = i_instr[15:0];
    assign o_wb_kind = classify_opcode(i_instr[31:26]);

endmodule

// File: rtl/alu_exec_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WB) that feeds the register file and
// ALU for one instruction and retires it with a write-back or branch pulse.
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int PROTECT_R0 = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_instr_valid,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_instr_pc,
    output logic              o_instr_ready,
    output logic [REG_AW-1:0] o_rf_raddr1,
    output logic [REG_AW-1:0] o_rf_raddr2,
    input  logic [DATA_W-1:0] i_rf_rdata1,
    input  logic [DATA_W-1:0] i_rf_rdata2,
    output logic [5:0]        o_alu_opcode,
    output logic [DATA_W-1:0] o_alu_rs_val,
    output logic [DATA_W-1:0] o_alu_rt_val,
    output logic [4:0]        o_alu_shamt,
    output logic [5:0]        o_alu_func,
    output logic [15:0]       o_alu_raw_val,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_alu_sig_b,
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_br_valid,
    output logic              o_br_taken,
    output logic [DATA_W-1:0] o_br_target,
    output logic              o_done,
    output logic              o_illegal
);

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rs_val;
    logic [DATA_W-1:0] r_rt_val;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_br_valid;
    logic              r_br_taken;
    logic [DATA_W-1:0] r_br_target;
    logic              r_done;
    logic              r_illegal;

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm;
    wb_kind_t          w_wb_kind;
    logic [REG_AW-1:0] w_waddr;
    logic              w_write_blocked;
    logic [DATA_W-1:0] w_pc_plus4;
    logic [DATA_W-1:0] w_br_offset;

    instr_field_decode u_decode (
        .i_instr   (r_instr),
        .o_opcode  (w_opcode),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_rd      (w_rd),
        .o_shamt   (w_shamt),
        .o_funct   (w_funct),
        .o_imm     (w_imm),
        .o_wb_kind (w_wb_kind)
    );

    assign w_pc_plus4      = r_pc + DATA_W'(4);
    assign w_br_offset     = {{(DATA_W-16){w_imm[15]}}, w_imm} << 2;
    assign w_waddr         = (w_wb_kind == RTYPE_WB) ? REG_AW'(w_rd) : REG_AW'(w_rt);
    assign w_write_blocked = (PROTECT_R0 != 0) && (w_waddr == '0);

    always_comb begin
        w_state_next  = r_state;
        o_instr_ready = 1'b0;
        case (r_state)
            IDLE: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) begin
                    w_state_next = READ;
                end
            end
            READ:    w_state_next = EXEC;
            EXEC:    w_state_next = WB;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            r_pc        <= '0;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_br_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Retirement flags are single-cycle: only the EXEC exit raises them.
            r_rf_we    <= 1'b0;
            r_br_valid <= 1'b0;
            r_br_taken <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_instr_valid) begin
                        r_instr <= i_instr;
                        r_pc    <= i_instr_pc;
                    end
                end
                READ: begin
                    r_rs_val <= i_rf_rdata1;
                    r_rt_val <= i_rf_rdata2;
                end
                EXEC: begin
                    r_rf_wdata <= i_alu_result;
                    r_rf_waddr <= w_waddr;
                    r_done     <= 1'b1;
                    case (w_wb_kind)
                        RTYPE_WB, ITYPE_WB: r_rf_we <= !w_write_blocked;
                        BRANCH: begin
                            r_br_valid  <= 1'b1;
                            r_br_taken  <= i_alu_sig_b;
                            r_br_target <= i_alu_sig_b ? (w_pc_plus4 + w_br_offset) : w_pc_plus4;
                        end
                        default: r_illegal <= 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign o_rf_raddr1   = REG_AW'(w_rs);
    assign o_rf_raddr2   = REG_AW'(w_rt);
    assign o_alu_opcode  = w_opcode;
    assign o_alu_rs_val  = r_rs_val;
    assign o_alu_rt_val  = r_rt_val;
    assign o_alu_shamt   = w_shamt;
    assign o_alu_func    = w_funct;
    assign o_alu_raw_val = w_imm;
    assign o_rf_we       = r_rf_we;
    assign o_rf_waddr    = r_rf_waddr;
    assign o_rf_wdata    = r_rf_wdata;
    assign o_br_valid    = r_br_valid;
    assign o_br_taken    = r_br_taken;
    assign o_br_target   = r_br_target;
    assign o_done        = r_done;
    assign o_illegal     = r_illegal;

endmodule
